// File: rtl/fetch_pc_unit_pkg.sv
// fetch_pc_unit_pkg: shared fetch-stage definitions (state encodings, NOP word, default reset vector).
package fetch_pc_unit_pkg;

    typedef enum logic [2:0] {
        FS_IDLE = 3'd0,
        FS_REQ  = 3'd1,
        FS_WAIT = 3'd2,
        FS_HOLD = 3'd3,
        FS_HALT = 3'd4
    } fetch_state_t;

    localparam logic [31:0] INSTR_NOP        = 32'h0000_0000;
    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;

    function automatic logic is_aligned(input logic [1:0] lo);
        return lo == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_pc_unit_pc_reg.sv
// pc_reg: program counter register with load enable and wrapping PC+4 adder.
module pc_reg #(
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_next,
    output logic [ADDR_W-1:0] o_pc,
    output logic [ADDR_W-1:0] o_pc_plus4
);

    logic [ADDR_W-1:0] r_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_pc <= RESET_VECTOR;
        else if (i_load) r_pc <= i_next;
    end

    assign o_pc       = r_pc;
    assign o_pc_plus4 = r_pc + ADDR_W'(4);

endmodule

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: PC holder and imem fetch handshake feeding decode one instruction at a time.
// Optional FETCH_PERF_CNT_EN adds FetchCount/StallCount outputs.
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(DEF_RESET_VECTOR)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] NextPC,
    output logic [ADDR_W-1:0] PC,
    output logic [ADDR_W-1:0] PCPlus4,
    output logic              ImemReq,
    output logic [ADDR_W-1:0] ImemAddr,
    input  logic              ImemGnt,
    input  logic              ImemRValid,
    input  logic [31:0]       ImemRData,
    output logic [31:0]       Instr,
    output logic              InstrValid,
    input  logic              InstrReady,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]       FetchCount,
    output logic [31:0]       StallCount,
`endif
    output logic              MisalignErr
);

    fetch_state_t r_state, w_next_state;
    logic [31:0]  r_instr;
    logic         r_misalign;
    logic         w_capture;
    logic         w_retire;

    pc_reg #(
        .ADDR_W       (ADDR_W),
        .RESET_VECTOR (RESET_VECTOR)
    ) u_pc_reg (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_retire),
        .i_next     (NextPC),
        .o_pc       (PC),
        .o_pc_plus4 (PCPlus4)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= FS_IDLE;
        else r_state <= w_next_state;
    end

    // Responses outside REQ/WAIT and ready outside HOLD fall through untouched.
    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        w_retire     = 1'b0;
        case (r_state)
            FS_IDLE: w_next_state = FS_REQ;
            FS_REQ: begin
                if (ImemGnt) begin
                    w_capture    = ImemRValid;
                    w_next_state = ImemRValid ? FS_HOLD : FS_WAIT;
                end
            end
            FS_WAIT: begin
                if (ImemRValid) begin
                    w_capture    = 1'b1;
                    w_next_state = FS_HOLD;
                end
            end
            FS_HOLD: begin
                if (InstrReady) begin
                    w_retire     = 1'b1;
                    w_next_state = is_aligned(NextPC[1:0]) ? FS_REQ : FS_HALT;
                end
            end
            FS_HALT: w_next_state = FS_HALT;
            default: w_next_state = FS_HALT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instr    <= INSTR_NOP;
            r_misalign <= 1'b0;
        end else begin
            if (w_capture) r_instr <= ImemRData;
            if (w_retire && !is_aligned(NextPC[1:0])) r_misalign <= 1'b1;
        end
    end

    assign ImemReq     = r_state == FS_REQ;
    assign ImemAddr    = PC;
    assign Instr       = r_instr;
    assign InstrValid  = r_state == FS_HOLD;
    assign MisalignErr = r_misalign;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_stall_cnt;
    logic        w_stall;

    assign w_stall = (r_state == FS_REQ  && !ImemGnt)
                   | (r_state == FS_WAIT && !ImemRValid)
                   | (r_state == FS_HOLD && !InstrReady);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_retire) r_fetch_cnt <= r_fetch_cnt + 32'd1;
            if (w_stall) r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign FetchCount = r_fetch_cnt;
    assign StallCount = r_stall_cnt;
`else
`endif

endmodule
